// File: rtl/ram_pkg.sv
// Shared helpers for dual_port_ram_pipe: address-split widths and byte-lane merge.
package ram_pkg;

    function automatic int offset_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       byte_en);
        return byte_en ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// LATENCY-deep valid/payload delay line; payload only loads with valid so the output holds
// its last response. Asynchronous active-low clear.
module ram_rd_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            logic             valid_d;
            logic             valid_q;
            logic [WIDTH-1:0] data_d;
            logic [WIDTH-1:0] data_q;

            if (gi == 0) begin : g_head
                assign valid_d = valid_i;
                assign data_d  = data_i;
            end else begin : g_tail
                assign valid_d = g_stage[gi-1].valid_q;
                assign data_d  = g_stage[gi-1].data_q;
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    if (valid_d) begin
                        data_q <= data_d;
                    end
                end
            end
        end
    endgenerate

    assign valid_o = g_stage[LATENCY-1].valid_q;
    assign data_o  = g_stage[LATENCY-1].data_q;

endmodule

// File: rtl/dual_port_ram_pipe.sv
// Shared-array RAM: read-only i-port, read/write byte-enabled d-port, write-first, fixed latency.
// Define RAM_ERR_EN to add i_err/d_err for misaligned or out-of-range addresses.
module dual_port_ram_pipe
    import ram_pkg::*;
#(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 16,
    parameter int    DEPTH        = 1024,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      i_req,
    input  logic [ADDR_WIDTH-1:0]     i_address,
    output logic                      i_valid,
    output logic [DATA_WIDTH-1:0]     i_read_data,
`ifdef RAM_ERR_EN
    output logic                      i_err,
    output logic                      d_err,
`endif
    input  logic                      d_req,
    input  logic                      wEn,
    input  logic [DATA_WIDTH/8-1:0]   d_byte_en,
    input  logic [ADDR_WIDTH-1:0]     d_address,
    input  logic [DATA_WIDTH-1:0]     d_write_data,
    output logic                      d_valid,
    output logic [DATA_WIDTH-1:0]     d_read_data
);

    localparam int OB = offset_bits(DATA_WIDTH);
    localparam int IW = index_width(DEPTH);
    localparam int NB = DATA_WIDTH / 8;
`ifdef RAM_ERR_EN
    localparam int PW = DATA_WIDTH + 1;
`else
    localparam int PW = DATA_WIDTH;
`endif

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [IW-1:0]         i_idx_d, d_idx_d, i_idx_q, d_idx_q;
    logic                  i_bad_d, d_bad_d, i_bad_q, d_bad_q;
    logic                  i_req_q, d_req_q;
    logic                  d_wr_d;
    logic [DATA_WIDTH-1:0] i_word_d, d_word_d;
    logic [PW-1:0]         i_pay_d, i_pay_q, d_pay_d, d_pay_q;

    assign i_idx_d = i_address[OB +: IW];
    assign d_idx_d = d_address[OB +: IW];

`ifdef RAM_ERR_EN
    function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] addr);
        return ((addr & ADDR_WIDTH'(NB - 1)) != '0) || ((addr >> (OB + IW)) != '0);
    endfunction

    assign i_bad_d = addr_bad(i_address);
    assign d_bad_d = addr_bad(d_address);
`else
    // Offset and upper address bits are deliberately ignored: the index wraps modulo DEPTH.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_address, d_address};
    assign i_bad_d = 1'b0;
    assign d_bad_d = 1'b0;
`endif

    // Writes commit at the request edge; erroring writes never touch the array.
    assign d_wr_d = d_req && wEn && !d_bad_d;

    always_ff @(posedge clock) begin
        if (d_wr_d) begin
            for (int b = 0; b < NB; b++) begin
                mem_q[d_idx_d][b*8 +: 8] <= merge_byte(mem_q[d_idx_d][b*8 +: 8],
                                                       d_write_data[b*8 +: 8], d_byte_en[b]);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            i_req_q <= 1'b0;
            i_idx_q <= '0;
            i_bad_q <= 1'b0;
            d_req_q <= 1'b0;
            d_idx_q <= '0;
            d_bad_q <= 1'b0;
        end else begin
            i_req_q <= i_req;
            i_idx_q <= i_idx_d;
            i_bad_q <= i_bad_d;
            d_req_q <= d_req;
            d_idx_q <= d_idx_d;
            d_bad_q <= d_bad_d;
        end
    end

    // The array is read one edge after the request, so any same-edge write (including the
    // d-port's own write) is already merged in: write-first on both ports with no bypass path.
    assign i_word_d = i_bad_q ? '0 : mem_q[i_idx_q];
    assign d_word_d = d_bad_q ? '0 : mem_q[d_idx_q];

`ifdef RAM_ERR_EN
    assign i_pay_d = {i_bad_q, i_word_d};
    assign d_pay_d = {d_bad_q, d_word_d};
    assign {i_err, i_read_data} = i_pay_q;
    assign {d_err, d_read_data} = d_pay_q;
`else
    assign i_pay_d     = i_word_d;
    assign d_pay_d     = d_word_d;
    assign i_read_data = i_pay_q;
    assign d_read_data = d_pay_q;
`endif

    ram_rd_pipe #(.WIDTH(PW), .LATENCY(READ_LATENCY)) u_i_pipe (
        .clock   (clock),
        .reset   (reset),
        .valid_i (i_req_q),
        .data_i  (i_pay_d),
        .valid_o (i_valid),
        .data_o  (i_pay_q)
    );

    ram_rd_pipe #(.WIDTH(PW), .LATENCY(READ_LATENCY)) u_d_pipe (
        .clock   (clock),
        .reset   (reset),
        .valid_i (d_req_q),
        .data_i  (d_pay_d),
        .valid_o (d_valid),
        .data_o  (d_pay_q)
    );

endmodule

// File: tb/tb_dual_port_ram_pipe.sv
// Scoreboard bench: one stimulus stream drives a READ_LATENCY=1 and a READ_LATENCY=3 instance;
// a word-array model predicts every response, a negedge monitor pops and compares.
module tb_dual_port_ram_pipe;

    localparam int DEPTH = 64;
`ifdef RAM_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
        bit          known;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req = 1'b1;
    logic [15:0] i_address = 16'h0010;
    logic        d_req = 1'b0;
    logic        wEn = 1'b0;
    logic [3:0]  d_byte_en = 4'h0;
    logic [15:0] d_address = 16'h0;
    logic [31:0] d_write_data = 32'h0;

    logic        i_valid1, d_valid1, i_valid3, d_valid3;
    logic [31:0] i_rd1, d_rd1, i_rd3, d_rd3;
    logic        i_err1, d_err1, i_err3, d_err3;

    logic [31:0] model_mem   [DEPTH];
    bit          model_known [DEPTH];
    exp_t        exp_q [4][$];
    logic [31:0] last_data  [4];
    bit          last_known [4];
    string       pname [4] = '{"i_rl1", "d_rl1", "i_rl3", "d_rl3"};

    int cyc = 0;
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dual_port_ram_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(DEPTH),
                         .READ_LATENCY(1), .INIT_FILE("")) u_dut_rl1 (
        .clock(clk), .reset(rst_n),
        .i_req(i_req), .i_address(i_address), .i_valid(i_valid1), .i_read_data(i_rd1),
`ifdef RAM_ERR_EN
        .i_err(i_err1), .d_err(d_err1),
`endif
        .d_req(d_req), .wEn(wEn), .d_byte_en(d_byte_en), .d_address(d_address),
        .d_write_data(d_write_data), .d_valid(d_valid1), .d_read_data(d_rd1)
    );

    dual_port_ram_pipe #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(DEPTH),
                         .READ_LATENCY(3), .INIT_FILE("")) u_dut_rl3 (
        .clock(clk), .reset(rst_n),
        .i_req(i_req), .i_address(i_address), .i_valid(i_valid3), .i_read_data(i_rd3),
`ifdef RAM_ERR_EN
        .i_err(i_err3), .d_err(d_err3),
`endif
        .d_req(d_req), .wEn(wEn), .d_byte_en(d_byte_en), .d_address(d_address),
        .d_write_data(d_write_data), .d_valid(d_valid3), .d_read_data(d_rd3)
    );

`ifndef RAM_ERR_EN
    assign i_err1 = 1'b0;
    assign d_err1 = 1'b0;
    assign i_err3 = 1'b0;
    assign d_err3 = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference rules: byte address -> word (addr/4 mod DEPTH); error on misalignment or range.
    function automatic logic model_bad(input logic [15:0] a);
        logic bad;
        bad = (int'(a) % 4 != 0) || (int'(a) / 4 >= DEPTH);
        return bad && ERR_ON;
    endfunction

    function automatic int model_idx(input logic [15:0] a);
        return (int'(a) / 4) % DEPTH;
    endfunction

    task automatic push_resp(input int port, input int n, input logic [31:0] data,
                             input logic err, input bit known);
        exp_t e;
        e.data  = data;
        e.err   = err;
        e.known = known;
        e.cyc   = n + 1;
        exp_q[port].push_back(e);
        e.cyc   = n + 3;
        exp_q[port + 2].push_back(e);
    endtask

    task automatic model_issue(input logic ir, input logic [15:0] ia, input logic dr,
                               input logic we, input logic [3:0] be, input logic [15:0] da,
                               input logic [31:0] wd);
        int n;
        n = cyc + 1;
        if (dr) begin
            logic bad;
            int   idx;
            bad = model_bad(da);
            idx = model_idx(da);
            if (we && !bad) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[idx][b*8 +: 8] = wd[b*8 +: 8];
                if (be == 4'hF) model_known[idx] = 1'b1;
            end
            push_resp(1, n, bad ? 32'h0 : model_mem[idx], bad, bad || model_known[idx]);
        end
        if (ir) begin
            logic bad;
            int   idx;
            bad = model_bad(ia);
            idx = model_idx(ia);
            push_resp(0, n, bad ? 32'h0 : model_mem[idx], bad, bad || model_known[idx]);
        end
    endtask

    task automatic step(input logic ir, input logic [15:0] ia, input logic dr, input logic we,
                        input logic [3:0] be, input logic [15:0] da, input logic [31:0] wd);
        i_req        = ir;
        i_address    = ia;
        d_req        = dr;
        wEn          = we;
        d_byte_en    = be;
        d_address    = da;
        d_write_data = wd;
        if (rst_n) model_issue(ir, ia, dr, we, be, da, wd);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 16'($urandom_range(0, 511));
        return 16'($urandom_range(0, 15) * 4);
    endfunction

    // Monitor: drops expectations while reset is low, then pops one entry per valid.
    always @(negedge clk) begin
        logic        vv [4];
        logic [31:0] dd [4];
        logic        ee [4];
        exp_t        e;
        vv = '{i_valid1, d_valid1, i_valid3, d_valid3};
        dd = '{i_rd1, d_rd1, i_rd3, d_rd3};
        ee = '{i_err1, d_err1, i_err3, d_err3};
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
                exp_q[k].delete();
                last_data[k]  = 32'h0;
                last_known[k] = 1'b1;
            end
            while (exp_q[k].size() > 0 && exp_q[k][0].cyc < cyc) begin
                checks++;
                $display("FAIL %s_missing: no response seen, due cycle %0d, now %0d",
                         pname[k], exp_q[k][0].cyc, cyc);
                void'(exp_q[k].pop_front());
            end
            if (vv[k]) begin
                if (exp_q[k].size() == 0) begin
                    checks++;
                    $display("FAIL %s_unexpected: valid=1 data=0x%08h at cycle %0d, expected valid=0",
                             pname[k], dd[k], cyc);
                end else begin
                    e = exp_q[k].pop_front();
                    check({pname[k], "_cycle"}, 32'(cyc), 32'(e.cyc));
                    if (e.known) check({pname[k], "_data"}, dd[k], e.data);
`ifdef RAM_ERR_EN
                    check({pname[k], "_err"}, {31'h0, ee[k]}, {31'h0, e.err});
`endif
                    $display("%s cyc=%0d data=0x%08h err=%b", pname[k], cyc, dd[k], ee[k]);
                    last_data[k]  = e.data;
                    last_known[k] = e.known;
                end
            end else if (last_known[k]) begin
                check({pname[k], "_hold"}, dd[k], last_data[k]);
            end
        end
    end

    initial begin
        for (int w = 0; w < DEPTH; w++) model_known[w] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            last_data[k]  = 32'h0;
            last_known[k] = 1'b1;
        end

        // Reset held three cycles with an instruction request pending.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("rst_valids", {28'h0, i_valid1, d_valid1, i_valid3, d_valid3}, 32'h0);
        end
        rst_n = 1'b1;
        step(1'b1, 16'h0010, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);

        // Fill every word so later reads are fully predictable.
        for (int w = 0; w < DEPTH; w++)
            step(1'($urandom_range(0, 1)), rand_addr(), 1'b1, 1'b1, 4'hF, 16'(w * 4), $urandom());

        // Full write, read back, partial byte write, read back.
        step(1'b0, 16'h0, 1'b1, 1'b1, 4'hF, 16'h0010, 32'hDEADBEEF);
        step(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0010, 32'h0);
        step(1'b0, 16'h0, 1'b1, 1'b1, 4'h1, 16'h0010, 32'h000000AA);
        step(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0010, 32'h0);

        // Same-edge write and instruction read, then a no-op write to the same word.
        step(1'b1, 16'h0020, 1'b1, 1'b1, 4'hF, 16'h0020, 32'h12345678);
        step(1'b1, 16'h0020, 1'b1, 1'b1, 4'h0, 16'h0020, 32'hFFFFFFFF);

        // Back-to-back reads, then two reads cut off by a reset pulse.
        step(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0000, 32'h0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0004, 32'h0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0008, 32'h0);
        repeat (4) idle();
        step(1'b1, 16'h0000, 1'b1, 1'b0, 4'h0, 16'h0000, 32'h0);
        step(1'b1, 16'h0004, 1'b1, 1'b0, 4'h0, 16'h0004, 32'h0);
        rst_n  = 1'b0;
        i_req  = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) idle();

        // Misaligned accesses: error responses, or aliasing onto word 0x10 without checking.
        step(1'b1, 16'h0011, 1'b0, 1'b0, 4'h0, 16'h0, 32'h0);
        step(1'b0, 16'h0, 1'b1, 1'b1, 4'hF, 16'h0011, 32'hCAFEF00D);
        step(1'b1, 16'h0010, 1'b1, 1'b0, 4'h0, 16'h0010, 32'h0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0400, 32'h0);

        // Randomised mixed traffic concentrated on a few words to force collisions.
        repeat (400)
            step(1'($urandom_range(0, 1)), rand_addr(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(), $urandom());

        repeat (6) idle();
        for (int k = 0; k < 4; k++)
            check({pname[k], "_drain"}, 32'(exp_q[k].size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
